// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RD   = 2'd1,
        RESP_HOLD = 2'd2
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    // Width of a counter that must reach timeout-1
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mem_arb_resp_buf.sv
// rtl/mem_arb_resp_buf.sv - one-entry read response holding register
module mem_arb_resp_buf #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] din,
    output logic          valid,
    output logic [DW-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (clear) begin
            valid <= 1'b0;
            dout  <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the single memory port
// MEMARB_RR_EN selects round-robin arbitration; otherwise req1 has fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int LW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_addr_valid,
    output logic          req0_addr_ready,
    input  logic          req0_wen,
    input  logic [AW-1:0] req0_addr,
    input  logic [LW-1:0] req0_len,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_data_valid,
    input  logic          req0_data_ready,
    output logic [DW-1:0] req0_rdata,
    input  logic          req1_addr_valid,
    output logic          req1_addr_ready,
    input  logic          req1_wen,
    input  logic [AW-1:0] req1_addr,
    input  logic [LW-1:0] req1_len,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_data_valid,
    input  logic          req1_data_ready,
    output logic [DW-1:0] req1_rdata,
    output logic          mem_en,
    output logic          mem_wout,
    output logic          mem_addr_valid,
    input  logic          mem_addr_ready,
    output logic [AW-1:0] mem_addr,
    output logic [LW-1:0] mem_len,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_data_ready,
    input  logic          mem_data_valid,
    input  logic [DW-1:0] mem_rdata,
    output logic          err_timeout,
    output logic          err_spurious
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          owner_q;
    logic [CW-1:0] cnt_q;
    logic          any_valid, win, win_wen, issue_en, accept, owner_ready;
    logic          owner_dv, buf_load, buf_clear, buf_valid;
    logic [DW-1:0] owner_rdata, buf_data;

    assign any_valid = req0_addr_valid | req1_addr_valid;

`ifdef MEMARB_RR_EN
    logic rr_ptr_q;

    always_comb begin
        if (req0_addr_valid && req1_addr_valid) win = rr_ptr_q;
        else                                    win = req1_addr_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rr_ptr_q <= REQ_IF;
        else if (accept) rr_ptr_q <= ~win;
    end
`else
    assign win = req1_addr_valid;
`endif

    assign win_wen     = (win == REQ_LS) ? req1_wen : req0_wen;
    assign owner_ready = (owner_q == REQ_LS) ? req1_data_ready : req0_data_ready;

    // A new request may issue from IDLE, or in the cycle the held response drains
    assign issue_en = (state_q == IDLE) || ((state_q == RESP_HOLD) && owner_ready);
    assign accept   = issue_en && any_valid && mem_addr_ready;

    assign mem_addr_valid  = issue_en && any_valid;
    assign mem_en          = mem_addr_valid;
    assign mem_wout        = mem_addr_valid && win_wen;
    assign mem_addr        = !mem_addr_valid ? '0 : (win == REQ_LS) ? req1_addr  : req0_addr;
    assign mem_len         = !mem_addr_valid ? '0 : (win == REQ_LS) ? req1_len   : req0_len;
    assign mem_wdata       = !mem_addr_valid ? '0 : (win == REQ_LS) ? req1_wdata : req0_wdata;
    assign mem_data_ready  = (state_q == WAIT_RD) || (mem_addr_valid && win_wen);
    assign req0_addr_ready = accept && (win == REQ_IF);
    assign req1_addr_ready = accept && (win == REQ_LS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        owner_dv    = 1'b0;
        owner_rdata = '0;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !win_wen) state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (mem_data_valid) begin
                    owner_dv    = 1'b1;
                    owner_rdata = mem_rdata;
                    if (owner_ready) begin
                        state_d = IDLE;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = RESP_HOLD;
                    end
                end
            end
            RESP_HOLD: begin
                owner_dv    = buf_valid;
                owner_rdata = buf_data;
                if (owner_ready) begin
                    buf_clear = 1'b1;
                    state_d   = (accept && !win_wen) ? WAIT_RD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mem_arb_resp_buf #(.DW(DW)) u_resp_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (mem_rdata),
        .valid (buf_valid),
        .dout  (buf_data)
    );

    assign req0_data_valid = owner_dv && (owner_q == REQ_IF);
    assign req1_data_valid = owner_dv && (owner_q == REQ_LS);
    assign req0_rdata      = req0_data_valid ? owner_rdata : '0;
    assign req1_rdata      = req1_data_valid ? owner_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= REQ_IF;
            cnt_q        <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (accept && !win_wen) owner_q <= win;
            if (accept)
                cnt_q <= '0;
            else if (state_q == WAIT_RD && cnt_q != CNT_LAST)
                cnt_q <= cnt_q + 1'b1;
            if (state_q == WAIT_RD && !mem_data_valid && cnt_q == CNT_LAST)
                err_timeout <= 1'b1;
            if (mem_data_valid && state_q != WAIT_RD)
                err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk, rst_n;
    logic        req0_addr_valid, req0_addr_ready, req0_wen, req0_data_valid, req0_data_ready;
    logic [63:0] req0_addr, req0_wdata, req0_rdata;
    logic [31:0] req0_len;
    logic        req1_addr_valid, req1_addr_ready, req1_wen, req1_data_valid, req1_data_ready;
    logic [63:0] req1_addr, req1_wdata, req1_rdata;
    logic [31:0] req1_len;
    logic        mem_en, mem_wout, mem_addr_valid, mem_addr_ready, mem_data_ready, mem_data_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem_len;
    logic        err_timeout, err_spurious;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_addr_valid(req0_addr_valid), .req0_addr_ready(req0_addr_ready), .req0_wen(req0_wen),
        .req0_addr(req0_addr), .req0_len(req0_len), .req0_wdata(req0_wdata),
        .req0_data_valid(req0_data_valid), .req0_data_ready(req0_data_ready), .req0_rdata(req0_rdata),
        .req1_addr_valid(req1_addr_valid), .req1_addr_ready(req1_addr_ready), .req1_wen(req1_wen),
        .req1_addr(req1_addr), .req1_len(req1_len), .req1_wdata(req1_wdata),
        .req1_data_valid(req1_data_valid), .req1_data_ready(req1_data_ready), .req1_rdata(req1_rdata),
        .mem_en(mem_en), .mem_wout(mem_wout), .mem_addr_valid(mem_addr_valid),
        .mem_addr_ready(mem_addr_ready), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_data_ready(mem_data_ready), .mem_data_valid(mem_data_valid),
        .mem_rdata(mem_rdata), .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue whatever requests are currently valid, expect requester w to win, return data d
    task automatic read_round(input int w, input logic [63:0] d);
        #1;
        check("issue_rdy0", 64'(req0_addr_ready), 64'(w == 0));
        check("issue_rdy1", 64'(req1_addr_ready), 64'(w == 1));
        check("issue_av", 64'(mem_addr_valid), 64'd1);
        tick;
        #1;
        check("wait_no_issue", 64'(mem_addr_valid), 64'd0);
        check("wait_dready", 64'(mem_data_ready), 64'd1);
        check("wait_no_dv", 64'(req0_data_valid | req1_data_valid), 64'd0);
        tick;
        tick;
        mem_data_valid = 1'b1;
        mem_rdata      = d;
        #1;
        check("ret_dv0", 64'(req0_data_valid), 64'(w == 0));
        check("ret_dv1", 64'(req1_data_valid), 64'(w == 1));
        check("ret_rdata", (w == 0) ? req0_rdata : req1_rdata, d);
        check("ret_other_rdata", (w == 0) ? req1_rdata : req0_rdata, 64'd0);
        tick;
        mem_data_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    int exp_w[4];

    initial begin
        rst_n = 1'b0;
        req0_addr_valid = 0; req0_wen = 0; req0_addr = 0; req0_len = 0; req0_wdata = 0; req0_data_ready = 0;
        req1_addr_valid = 0; req1_wen = 0; req1_addr = 0; req1_len = 0; req1_wdata = 0; req1_data_ready = 0;
        mem_addr_ready = 1'b1; mem_data_valid = 1'b0; mem_rdata = '0;
        tick;
        tick;
        check("rst_av", 64'(mem_addr_valid), 64'd0);
        check("rst_en", 64'(mem_en), 64'd0);
        check("rst_dready", 64'(mem_data_ready), 64'd0);
        check("rst_addr", mem_addr, 64'd0);
        check("rst_dv", 64'(req0_data_valid | req1_data_valid), 64'd0);
        check("rst_errs", 64'({err_timeout, err_spurious}), 64'd0);
        rst_n = 1'b1;
        tick;

        // 1: single read from req0
        req0_addr_valid = 1; req0_wen = 0; req0_addr = 64'h8000_0000; req0_len = 8; req0_data_ready = 1;
        #1;
        check("t1_mem_addr", mem_addr, 64'h8000_0000);
        check("t1_mem_len", 64'(mem_len), 64'd8);
        check("t1_wout", 64'(mem_wout), 64'd0);
        check("t1_dready", 64'(mem_data_ready), 64'd0);
        req0_addr_valid = 1;
        read_round(0, 64'h1111_2222_3333_4444);
        req0_addr_valid = 0;

        // 2: contention between both requesters
`ifdef MEMARB_RR_EN
        exp_w = '{1, 0, 1, 0};
`else
        exp_w = '{1, 1, 1, 1};
`endif
        req0_addr_valid = 1; req0_addr = 64'h8000_0100;
        req1_addr_valid = 1; req1_wen = 0; req1_addr = 64'h8000_0200; req1_len = 8; req1_data_ready = 1;
        for (int i = 0; i < 4; i++)
            read_round(exp_w[i], 64'hA000_0000 + 64'(i));
        req1_addr_valid = 0;
        read_round(0, 64'hB000_0000);
        req0_addr_valid = 0;

        // 3: back-to-back writes from req1
        req1_addr_valid = 1; req1_wen = 1; req1_addr = 64'h8000_1000; req1_len = 4; req1_wdata = 64'hDEAD;
        #1;
        check("t3_w1_rdy", 64'(req1_addr_ready), 64'd1);
        check("t3_w1_dready", 64'(mem_data_ready), 64'd1);
        check("t3_w1_wout", 64'(mem_wout), 64'd1);
        check("t3_w1_wdata", mem_wdata, 64'hDEAD);
        tick;
        req1_addr = 64'h8000_1008; req1_wdata = 64'hBEEF;
        #1;
        check("t3_w2_rdy", 64'(req1_addr_ready), 64'd1);
        check("t3_w2_addr", mem_addr, 64'h8000_1008);
        check("t3_w2_dready", 64'(mem_data_ready), 64'd1);
        check("t3_w2_no_dv", 64'(req1_data_valid), 64'd0);
        tick;
        req1_addr_valid = 0; req1_wen = 0;
        #1;
        check("t3_idle", 64'(mem_addr_valid | req1_data_valid), 64'd0);

        // 4: response held while req0 stalls
        req0_addr_valid = 1; req0_addr = 64'h8000_0040; req0_data_ready = 0;
        #1;
        check("t4_rdy", 64'(req0_addr_ready), 64'd1);
        tick;
        req0_addr_valid = 0;
        tick;
        tick;
        mem_data_valid = 1; mem_rdata = 64'h5555_6666;
        #1;
        check("t4_ret_dv", 64'(req0_data_valid), 64'd1);
        tick;
        mem_data_valid = 0; mem_rdata = '0;
        req1_addr_valid = 1; req1_addr = 64'h8000_0300;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_hold_dv", 64'(req0_data_valid), 64'd1);
            check("t4_hold_rdata", req0_rdata, 64'h5555_6666);
            check("t4_hold_no_issue", 64'({mem_addr_valid, req1_addr_ready}), 64'd0);
            tick;
        end
        req0_data_ready = 1;
        #1;
        check("t4_drain_dv", 64'(req0_data_valid), 64'd1);
        check("t4_drain_issue", 64'(req1_addr_ready), 64'd1);
        tick;
        req1_addr_valid = 0;
        #1;
        check("t4_drained", 64'(req0_data_valid), 64'd0);
        tick;
        mem_data_valid = 1; mem_rdata = 64'h7777;
        #1;
        check("t4_r1_dv", 64'(req1_data_valid), 64'd1);
        check("t4_r1_rdata", req1_rdata, 64'h7777);
        tick;
        mem_data_valid = 0; mem_rdata = '0;

        // 5: reset in the middle of a read
        req0_addr_valid = 1; req0_addr = 64'h8000_0080;
        #1;
        check("t5_rdy", 64'(req0_addr_ready), 64'd1);
        tick;
        req0_addr_valid = 0;
        rst_n = 0;
        #1;
        check("t5_rst_dready", 64'(mem_data_ready), 64'd0);
        check("t5_rst_av", 64'(mem_addr_valid), 64'd0);
        tick;
        rst_n = 1;
        tick;
        check("t5_no_spur_yet", 64'(err_spurious), 64'd0);
        mem_data_valid = 1; mem_rdata = 64'h9999;
        #1;
        check("t5_late_dropped", 64'(req0_data_valid), 64'd0);
        check("t5_late_rdata", req0_rdata, 64'd0);
        tick;
        mem_data_valid = 0; mem_rdata = '0;
        check("t5_spurious", 64'(err_spurious), 64'd1);

        // 6: read never returns
        req0_addr_valid = 1; req0_addr = 64'h8000_00C0;
        #1;
        check("t6_rdy", 64'(req0_addr_ready), 64'd1);
        tick;
        req0_addr_valid = 0;
        for (int i = 0; i < 15; i++) tick;
        check("t6_before_timeout", 64'(err_timeout), 64'd0);
        tick;
        check("t6_timeout", 64'(err_timeout), 64'd1);
        tick;
        tick;
        check("t6_sticky", 64'(err_timeout), 64'd1);
        rst_n = 0;
        #1;
        check("t6_rst_clear", 64'({err_timeout, err_spurious}), 64'd0);
        tick;
        rst_n = 1;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
